pipeline_control_unit: RTL and testbench
========================================

// Module: pipeline_control_unit
// PURPOSE
//  Successor to the single-cycle opcode decoder for the pipelined RV32 datapath.
//  - Decodes the ID-stage opcode into a control bundle.
//  - Carries the bundle through ID/EX, EX/MEM and MEM/WB control registers.
//  - Detects load-use hazards and inserts a parametrised number of bubbles.
//  - Flushes wrong-path instructions on a taken branch/jump resolved in EX.
// PARAMETERS
//  REG_ADDR_W   5  register-index width
//  ALUOP_W      2  ALUOp width (ALU decoder contract: 00 add, 01 sub/cmp, 10 funct-decoded)
//  LU_BUBBLES   1  bubbles per load-use hazard, legal 1..3
//  ENABLE_JUMP  1  1: decode JAL/JALR as jumps; 0: treat them as illegal
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high
//  opcode_id      in   7           ID-stage instruction[6:0]
//  rs1_id         in   REG_ADDR_W  ID-stage rs1 field
//  rs2_id         in   REG_ADDR_W  ID-stage rs2 field
//  rd_id          in   REG_ADDR_W  ID-stage rd field
//  take_ex        in   1           EX: branch condition true, or jump in EX
//  pc_write       out  1           PC load enable
//  ifid_write     out  1           IF/ID load enable
//  ifid_flush     out  1           zero IF/ID this edge
//  ex_aluop       out  ALUOP_W     ID/EX ALUOp
//  ex_alusrc      out  1           ID/EX ALUSrc
//  ex_branch      out  1           ID/EX Branch
//  ex_jump        out  1           ID/EX Jump
//  ex_rd          out  REG_ADDR_W  ID/EX rd
//  mem_read       out  1           EX/MEM MemRead
//  mem_write      out  1           EX/MEM MemWrite
//  wb_regwrite    out  1           MEM/WB RegWrite
//  wb_memtoreg    out  1           MEM/WB MemtoReg
//  wb_rd          out  REG_ADDR_W  MEM/WB rd
//  illegal_id     out  1           comb: unrecognised opcode in ID
// BEHAVIOUR
//  Decode (combinational, ID stage)
//  - R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011 and OP-IMM 0010011 use the legacy encodings.
//  - JAL 1101111 / JALR 1100111: Jump=1, RegWrite=1, ALUSrc=1, ALUOp=00.
//  - Any other opcode: all-zero bundle (no x), illegal_id=1.
//  Pipeline registers
//  - Each stage register updates every clk; one cycle per stage.
//  - Latency: opcode_id to ex_* is 1 cycle, to mem_* is 2, to wb_* is 3.
//  Hazard FSM
//  - States: RUN, STALL; cnt is 2 bits.
//  - RUN->STALL when ex_memread && ex_rd!=0 && ex_rd==rs1_id|rs2_id; cnt<=LU_BUBBLES-1.
//  - A STORE uses rs2; BRANCH and R types use both rs1 and rs2; other types use rs1 only.
//  - In STALL: pc_write=ifid_write=0 and a zero bundle enters ID/EX.
//  - In STALL, cnt decrements and the FSM returns to RUN when cnt==0 at the edge.
//  - The hazard check is also combinational in RUN, so the first bubble occurs in the detect cycle.
//  - Total stall is exactly LU_BUBBLES cycles.
//  Flush
//  - take_ex=1 && (ex_branch||ex_jump): ifid_flush=1 and a zero bundle enters ID/EX.
//  - Flush overrides any stall; FSM is forced to RUN and cnt cleared; pc_write=1.
//  Priority: reset > flush > stall > normal.
//  Reset
//  - All stage registers 0, FSM RUN, cnt 0.
//  - pc_write=ifid_write=1, ifid_flush=0.
//  - Reset mid-stall aborts the stall on the same edge.
//  Register x0: rd==0 never triggers a hazard; wb_regwrite is still passed through.
// STRUCTURE
//  - Package pcu_pkg: opcode localparams, ctrl_bundle_t struct, ZERO_BUNDLE constant.
//  - Sub-module pcu_decode: the combinational opcode decoder; the top holds the FSM and stage registers.
// TESTING
//  1. reset for 2 cycles, then R-type x3 dependency-free: ex_aluop=10 at +1; wb_regwrite=1 at +3; no stall.
//  2. lw x5; then add x6,x5,x1 with LU_BUBBLES=1: pc_write=0 for 1 cycle; one zero bundle in EX.
//  3. Same hazard with LU_BUBBLES=3: exactly 3 stall cycles, then the add reaches EX.
//  4. lw x0; then add x6,x0,x1: no stall.
//  5. beq in EX with take_ex=1 during a load-use stall: ifid_flush=1; FSM returns to RUN; pc_write=1.
//  6. Opcode 0000000: illegal_id=1; all-zero bundle through the pipeline; reset asserted mid-stall clears all outputs next edge.

Source files
------------

// File: rtl/pipeline_control_unit_pkg.sv
// Shared opcode constants, control-bundle type and hazard FSM states for the
// pipelined RV32 control unit.
package pcu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU decoder contract: add, sub/compare, funct-decoded
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t ZERO_BUNDLE = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_control_unit_decode.sv
// Combinational ID-stage opcode decoder: control bundle, illegal flag and
// which source registers the instruction actually reads.
module pcu_decode
  import pcu_pkg::*;
#(
  parameter int ENABLE_JUMP = 1
) (
  input  logic [6:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         use_rs1,
  output logic         use_rs2
);

  always_comb begin
    ctrl    = ZERO_BUNDLE;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.aluop    = ALU_FUNCT;
        ctrl.regwrite = 1'b1;
      end
      OP_LOAD: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      OP_STORE: begin
        ctrl.aluop     = ALU_ADD;
        ctrl.alusrc    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.aluop  = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_IMM: begin
        ctrl.aluop    = ALU_FUNCT;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        if (ENABLE_JUMP != 0) begin
          ctrl.aluop    = ALU_ADD;
          ctrl.alusrc   = 1'b1;
          ctrl.jump     = 1'b1;
          ctrl.regwrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Stores only expose rs2 to the hazard check; everything else reads rs1.
  assign use_rs1 = (opcode != OP_STORE);
  assign use_rs2 = (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_R);

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX, EX/MEM,
// MEM/WB, inserts load-use bubbles and flushes on a taken branch/jump in EX.
module pipeline_control_unit
  import pcu_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int LU_BUBBLES  = 1,
  parameter int ENABLE_JUMP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  take_ex,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal_id
);

  ctrl_bundle_t          id_ctrl;
  logic                  use_rs1;
  logic                  use_rs2;

  ctrl_bundle_t          ex_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_regwrite_q;
  logic                  mem_memtoreg_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;

  hz_state_t             state;
  logic [1:0]            cnt;

  logic                  flush;
  logic                  hazard;
  logic                  stall;
  logic                  bubble;

  pcu_decode #(
    .ENABLE_JUMP (ENABLE_JUMP)
  ) u_decode (
    .opcode  (opcode_id),
    .ctrl    (id_ctrl),
    .illegal (illegal_id),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign flush  = take_ex && (ex_q.branch || ex_q.jump);

  // Evaluated in RUN so the detect cycle itself already carries the first bubble.
  assign hazard = (state == ST_RUN) && ex_q.mem_read && (ex_rd_q != '0) &&
                  ((use_rs1 && (rs1_id == ex_rd_q)) || (use_rs2 && (rs2_id == ex_rd_q)));

  assign stall  = !flush && ((state == ST_STALL) || hazard);
  assign bubble = flush || stall;

  assign pc_write   = reset || !stall;
  assign ifid_write = reset || !stall;
  assign ifid_flush = !reset && flush;

  assign ex_aluop  = ALUOP_W'(ex_q.aluop);
  assign ex_alusrc = ex_q.alusrc;
  assign ex_branch = ex_q.branch;
  assign ex_jump   = ex_q.jump;
  assign ex_rd     = ex_rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q           <= ZERO_BUNDLE;
      ex_rd_q        <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_regwrite    <= 1'b0;
      wb_memtoreg    <= 1'b0;
      wb_rd          <= '0;
    end else begin
      ex_q           <= bubble ? ZERO_BUNDLE : id_ctrl;
      ex_rd_q        <= (bubble || illegal_id) ? '0 : rd_id;
      mem_read       <= ex_q.mem_read;
      mem_write      <= ex_q.mem_write;
      mem_regwrite_q <= ex_q.regwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      mem_rd_q       <= ex_rd_q;
      wb_regwrite    <= mem_regwrite_q;
      wb_memtoreg    <= mem_memtoreg_q;
      wb_rd          <= mem_rd_q;
    end
  end

  // cnt holds the bubbles still owed after the current one; the detect cycle
  // supplies the first bubble, so a single-bubble hazard never leaves RUN.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard && (LU_BUBBLES > 1)) begin
            state <= ST_STALL;
            cnt   <= 2'(LU_BUBBLES - 1);
          end
        end
        ST_STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench: two instances (1 and 3 load-use bubbles) driven from an
// instruction-stream model; a single negedge monitor compares every cycle.
module tb_pipeline_control_unit;

  localparam int W = 23;
  localparam int CYCLE_LIMIT = 20000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       m2r;
    logic [4:0] rd;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic timed_out = 1'b0;
  logic lane_done [2] = '{1'b0, 1'b0};

  logic [W-1:0] act [2];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Control table written straight from the instruction-class rules.
  function automatic ent_t ref_decode(input logic [6:0] o, input logic [4:0] d);
    ent_t e;
    e = '0;
    case (o)
      OP_R:      begin e.aluop = 2'b10; e.rw = 1'b1; end
      OP_LOAD:   begin e.alusrc = 1'b1; e.mr = 1'b1; e.rw = 1'b1; e.m2r = 1'b1; end
      OP_STORE:  begin e.alusrc = 1'b1; e.mw = 1'b1; end
      OP_BRANCH: begin e.aluop = 2'b01; e.branch = 1'b1; end
      OP_IMM:    begin e.aluop = 2'b10; e.alusrc = 1'b1; e.rw = 1'b1; end
      OP_JAL, OP_JALR: begin e.jump = 1'b1; e.rw = 1'b1; e.alusrc = 1'b1; end
      default:   e = '0;
    endcase
    if (!ref_illegal(o)) e.rd = d;
    return e;
  endfunction

  function automatic logic ref_illegal(input logic [6:0] o);
    return !(o == OP_R || o == OP_LOAD || o == OP_STORE || o == OP_BRANCH ||
             o == OP_IMM || o == OP_JAL || o == OP_JALR);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] o);
    return (o == OP_STORE) || (o == OP_BRANCH) || (o == OP_R);
  endfunction

  task automatic cmp(input int lane, input logic [W-1:0] e, input logic [W-1:0] a);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL lane%0d outputs t=%0t: got %h expected %h", lane, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q0.size() > 0) cmp(0, exp_q0.pop_front(), act[0]);
    if (exp_q1.size() > 0) cmp(1, exp_q1.pop_front(), act[1]);
    if (!timed_out && cyc > CYCLE_LIMIT && !(lane_done[0] && lane_done[1])) begin
      timed_out = 1'b1;
      n_checks++;
      n_fail++;
      $display("FAIL timeout: lanes done=%0b%0b after %0d cycles, required both done",
               lane_done[1], lane_done[0], cyc);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_lane
    localparam int LU = (g == 0) ? 1 : 3;

    logic       rst;
    logic [6:0] op;
    logic [4:0] r1, r2, rdd;
    logic       take;
    logic       pc_write, ifid_write, ifid_flush, illegal_id;
    logic [1:0] ex_aluop;
    logic       ex_alusrc, ex_branch, ex_jump;
    logic [4:0] ex_rd, wb_rd;
    logic       mem_read, mem_write, wb_regwrite, wb_memtoreg;

    ent_t m_ex, m_mem, m_wb;
    int   left;
    logic pred_stall, pred_flush;

    assign act[g] = {pc_write, ifid_write, ifid_flush, illegal_id, ex_aluop, ex_alusrc,
                     ex_branch, ex_jump, ex_rd, mem_read, mem_write, wb_regwrite,
                     wb_memtoreg, wb_rd};

    pipeline_control_unit #(
      .REG_ADDR_W  (5),
      .ALUOP_W     (2),
      .LU_BUBBLES  (LU),
      .ENABLE_JUMP (1)
    ) dut (
      .clk         (clk),
      .reset       (rst),
      .opcode_id   (op),
      .rs1_id      (r1),
      .rs2_id      (r2),
      .rd_id       (rdd),
      .take_ex     (take),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .ex_aluop    (ex_aluop),
      .ex_alusrc   (ex_alusrc),
      .ex_branch   (ex_branch),
      .ex_jump     (ex_jump),
      .ex_rd       (ex_rd),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .wb_regwrite (wb_regwrite),
      .wb_memtoreg (wb_memtoreg),
      .wb_rd       (wb_rd),
      .illegal_id  (illegal_id)
    );

    // One cycle: apply inputs, queue the expected outputs, advance the model at the edge.
    task automatic step(input logic rs, input logic [6:0] o, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic t);
      logic fl, hz, st;
      logic [W-1:0] e;
      rst = rs; op = o; r1 = a; r2 = b; rdd = d; take = t;
      fl = !rs && t && (m_ex.branch || m_ex.jump);
      hz = !rs && (left == 0) && m_ex.mr && (m_ex.rd != 5'd0) &&
           (((o != OP_STORE) && (a == m_ex.rd)) || (reads_rs2(o) && (b == m_ex.rd)));
      st = !rs && !fl && ((left > 0) || hz);
      e = {!st, !st, fl, ref_illegal(o), m_ex.aluop, m_ex.alusrc, m_ex.branch, m_ex.jump,
           m_ex.rd, m_mem.mr, m_mem.mw, m_wb.rw, m_wb.m2r, m_wb.rd};
      if (g == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      @(posedge clk);
      if (rs) begin
        m_ex = '0; m_mem = '0; m_wb = '0; left = 0;
      end else begin
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (fl || st) ? '0 : ref_decode(o, d);
        if (fl)            left = 0;
        else if (left > 0) left = left - 1;
        else if (hz)       left = LU - 1;
      end
      pred_stall = st;
      pred_flush = fl;
      #1;
    endtask

    // Present one instruction until it leaves ID; a flushed ID slot reads as zero.
    task automatic issue(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic t);
      int guard;
      guard = 0;
      do begin
        step(1'b0, o, a, b, d, t);
        guard++;
      end while (pred_stall && guard < 8);
      if (pred_flush) step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
      logic [6:0] ops [9];
      int sel;
      ops = '{OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_JAL, OP_JALR, OP_LOAD, 7'd0};
      rst = 1'b1; op = '0; r1 = '0; r2 = '0; rdd = '0; take = 1'b0;
      m_ex = '0; m_mem = '0; m_wb = '0; left = 0;
      pred_stall = 1'b0; pred_flush = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      step(1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      // independent R-types
      issue(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
      issue(OP_R, 5'd4, 5'd7, 5'd8, 1'b0);
      issue(OP_R, 5'd9, 5'd10, 5'd11, 1'b0);
      issue(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
      // lw x5; add x6,x5,x1
      issue(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
      issue(OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
      // x0 never hazards
      issue(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0);
      issue(OP_R, 5'd0, 5'd1, 5'd6, 1'b0);
      // store reads only rs2; branch reads rs2
      issue(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
      issue(OP_STORE, 5'd5, 5'd2, 5'd0, 1'b0);
      issue(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
      issue(OP_STORE, 5'd1, 5'd5, 5'd0, 1'b0);
      issue(OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b0);
      issue(OP_BRANCH, 5'd2, 5'd7, 5'd0, 1'b0);
      // take_ex without a branch/jump in EX does nothing, even while stalled
      issue(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
      issue(OP_R, 5'd5, 5'd1, 5'd6, 1'b1);
      // taken branch and jump flush; not-taken branch does not
      issue(OP_BRANCH, 5'd1, 5'd2, 5'd0, 1'b0);
      issue(OP_R, 5'd3, 5'd4, 5'd7, 1'b1);
      issue(OP_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
      issue(OP_IMM, 5'd1, 5'd0, 5'd2, 1'b1);
      issue(OP_BRANCH, 5'd1, 5'd2, 5'd0, 1'b0);
      issue(OP_R, 5'd3, 5'd4, 5'd7, 1'b0);
      // illegal opcode drains as an all-zero bundle
      issue(7'd0, 5'd3, 5'd4, 5'd9, 1'b0);
      issue(7'b1111111, 5'd0, 5'd0, 5'd9, 1'b0);
      for (int k = 0; k < 3; k++) issue(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
      // reset in the middle of a stall
      issue(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
      step(1'b0, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
      step(1'b0, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
      step(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
      issue(OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
      for (int k = 0; k < 3; k++) issue(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
      // randomized stream over a small register set to provoke hazards
      for (int n = 0; n < 300; n++) begin
        sel = $urandom_range(0, 8);
        if ($urandom_range(0, 49) == 0)
          step(1'b1, ops[sel], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        else
          issue(ops[sel], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 4; k++) issue(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0);
      lane_done[g] = 1'b1;
    end
  end

  initial begin
    wait ((lane_done[0] && lane_done[1]) || timed_out);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
